// File: rtl/alu_ctrl_dmem.sv
// Single-cycle datapath slice: main/ALU decoder, 32-bit ALU, word-addressed data memory, write-back mux.
// Optional macro DMEM_CLEAR_ON_RESET_EN: when defined, rst clears every memory word asynchronously.
module alu_ctrl_dmem #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] sign_imm,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic        alu_src,
  output logic        reg_dst,
  output logic        reg_write,
  output logic [2:0]  alu_control,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic        pc_src,
  output logic [31:0] read_data,
  output logic [31:0] result
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           b_s;
  logic [DEPTH_LOG2-1:0] index_s;
  logic [31:0]           mem_r [0:DEPTH-1];

  // Instruction decode; anything unrecognised leaves every control low and selects add.
  always_comb begin
    mem_to_reg  = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_src     = 1'b0;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    alu_control = 3'b010;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b010; end
          6'b100010: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b110; end
          6'b100100: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b000; end
          6'b100101: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b001; end
          6'b101010: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b111; end
          default:   alu_control = 3'b010;
        endcase
      end
      6'b100011: begin reg_write = 1'b1; alu_src = 1'b1; mem_to_reg = 1'b1; alu_control = 3'b010; end
      6'b101011: begin mem_write = 1'b1; alu_src = 1'b1; alu_control = 3'b010; end
      6'b000100: begin branch = 1'b1; alu_control = 3'b110; end
      6'b001000: begin reg_write = 1'b1; alu_src = 1'b1; alu_control = 3'b010; end
      6'b000010: jump = 1'b1;
      default:   alu_control = 3'b010;
    endcase
  end

  assign b_s = alu_src ? sign_imm : rd2;

  // ALU; arithmetic wraps modulo 2^32 and slt compares as signed.
  always_comb begin
    alu_out = 32'd0;
    case (alu_control)
      3'b000:  alu_out = rd1 & b_s;
      3'b001:  alu_out = rd1 | b_s;
      3'b010:  alu_out = rd1 + b_s;
      3'b110:  alu_out = rd1 - b_s;
      3'b111:  alu_out = {31'd0, ($signed(rd1) < $signed(b_s))};
      3'b100:  alu_out = rd1 & ~b_s;
      3'b101:  alu_out = rd1 | ~b_s;
      3'b011:  alu_out = 32'd0;
      default: alu_out = 32'd0;
    endcase
  end

  assign zero    = (alu_out == 32'd0);
  assign pc_src  = branch & zero;
  // Byte offset and bits above the memory size are dropped, so addresses wrap.
  assign index_s = alu_out[DEPTH_LOG2+1:2];

`ifdef DMEM_CLEAR_ON_RESET_EN
  // Word store; reset wipes the whole array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (mem_write) begin
      mem_r[index_s] <= rd2;
    end
  end
`else
  // Word store; reset only suppresses the write and keeps contents.
  always_ff @(posedge clk) begin
    if (mem_write && !rst) begin
      mem_r[index_s] <= rd2;
    end
  end
`endif

  assign read_data = mem_r[index_s];
  assign result    = mem_to_reg ? read_data : alu_out;

endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// Directed self-checking bench for alu_ctrl_dmem; expected values are hand-computed.
module tb_alu_ctrl_dmem;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] sign_imm;
  logic        mem_to_reg, mem_write, branch, jump, alu_src, reg_dst, reg_write;
  logic [2:0]  alu_control;
  logic [31:0] alu_out;
  logic        zero;
  logic        pc_src;
  logic [31:0] read_data;
  logic [31:0] result;

  int tests_run = 0;
  int tests_failed = 0;

  alu_ctrl_dmem #(.DEPTH_LOG2(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .rd1(rd1), .rd2(rd2), .sign_imm(sign_imm),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write), .branch(branch), .jump(jump),
    .alu_src(alu_src), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_control(alu_control), .alu_out(alu_out), .zero(zero), .pc_src(pc_src),
    .read_data(read_data), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: mem_to_reg mem_write branch jump alu_src reg_dst reg_write alu_control[2:0]
  function automatic logic [31:0] ctl();
    return {22'd0, mem_to_reg, mem_write, branch, jump, alu_src, reg_dst, reg_write, alu_control};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
    opcode = op; funct = fn; rd1 = a; rd2 = b; sign_imm = imm;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_after_rst;
    rst = 1'b1;
    drive(6'b000000, 6'b100000, 32'd3, 32'd4, 32'd0);
    // Combinational path is live while in reset
    check("rst_add_ctl", ctl(), 32'b00000_11_010);
    check("rst_add_out", alu_out, 32'd7);
    check("rst_add_result", result, 32'd7);
    edge_wait();
    edge_wait();
    rst = 1'b0;

    drive(6'b000000, 6'b100010, 32'd5, 32'd5, 32'd0);
    check("sub_ctl", ctl(), 32'b00000_11_110);
    check("sub_out", alu_out, 32'd0);
    check("sub_zero", {31'd0, zero}, 32'd1);

    drive(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0);
    check("slt_ctl", ctl(), 32'b00000_11_111);
    check("slt_neg", alu_out, 32'd1);
    check("slt_neg_zero", {31'd0, zero}, 32'd0);
    drive(6'b000000, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'd0);
    check("slt_pos", alu_out, 32'd0);

    drive(6'b000000, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
    check("and_out", alu_out, 32'h0000_F000);
    check("and_ctl", ctl(), 32'b00000_11_000);
    drive(6'b000000, 6'b100101, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
    check("or_out", alu_out, 32'h0000_FFF0);
    drive(6'b000000, 6'b100000, 32'hFFFF_FFFF, 32'd2, 32'd0);
    check("add_wrap", alu_out, 32'd1);
    drive(6'b000000, 6'b000000, 32'd9, 32'd3, 32'd0);
    check("bad_funct_ctl", ctl(), 32'b00000_00_010);
    check("bad_funct_out", alu_out, 32'd12);

    drive(6'b001000, 6'b000000, 32'd10, 32'd99, 32'hFFFF_FFFF);
    check("addi_ctl", ctl(), 32'b00001_01_010);
    check("addi_out", alu_out, 32'd9);

    drive(6'b000010, 6'b000000, 32'd0, 32'd0, 32'd0);
    check("j_ctl", ctl() >> 3, 32'b0001000);

    // Store then load at 0x14 (word 5)
    drive(6'b101011, 6'b000000, 32'h10, 32'hDEAD_BEEF, 32'd4);
    check("sw_ctl", ctl(), 32'b01001_00_010);
    check("sw_addr", alu_out, 32'h14);
    edge_wait();
    check("sw_visible", read_data, 32'hDEAD_BEEF);
    drive(6'b100011, 6'b000000, 32'h10, 32'd0, 32'd4);
    check("lw_ctl", ctl(), 32'b10001_01_010);
    check("lw_read", read_data, 32'hDEAD_BEEF);
    check("lw_result", result, 32'hDEAD_BEEF);

    drive(6'b101011, 6'b000000, 32'h18, 32'h1111_2222, 32'd0);
    edge_wait();
    drive(6'b100011, 6'b000000, 32'h18, 32'd0, 32'd0);
    check("lw_word6", result, 32'h1111_2222);
    // 0x117 keeps only bits [7:2] -> word 5
    drive(6'b100011, 6'b000000, 32'h113, 32'd0, 32'd4);
    check("lw_wrap", read_data, 32'hDEAD_BEEF);

    drive(6'b000100, 6'b000000, 32'd7, 32'd7, 32'd0);
    check("beq_ctl", ctl(), 32'b00100_00_110);
    check("beq_taken", {31'd0, pc_src}, 32'd1);
    drive(6'b000100, 6'b000000, 32'd7, 32'd8, 32'd0);
    check("beq_not_taken", {31'd0, pc_src}, 32'd0);

    drive(6'b111111, 6'b000000, 32'h10, 32'h1234_5678, 32'd4);
    check("unk_ctl", ctl(), 32'b00000_00_010);
    edge_wait();
    drive(6'b100011, 6'b000000, 32'h10, 32'd0, 32'd4);
    check("unk_no_write", read_data, 32'hDEAD_BEEF);

    // Store attempted while reset is held
    drive(6'b101011, 6'b000000, 32'h10, 32'hCAFE_F00D, 32'd4);
    rst = 1'b1;
    #1;
    check("rst_sw_ctl", ctl(), 32'b01001_00_010);
    check("rst_sw_addr", alu_out, 32'h14);
    edge_wait();
    rst = 1'b0;
    drive(6'b100011, 6'b000000, 32'h10, 32'd0, 32'd4);
`ifdef DMEM_CLEAR_ON_RESET_EN
    exp_after_rst = 32'd0;
`else
    exp_after_rst = 32'hDEAD_BEEF;
`endif
    check("rst_blocks_sw", read_data, exp_after_rst);
    check("rst_blocks_sw_res", result, exp_after_rst);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_dmem.md
ALU_CTRL_DMEM -- requirements
Module: alu_ctrl_dmem

Interface
REQ-001 Parameter DEPTH_LOG2, default 6, log2 of data-memory depth in 32-bit words (64 words).
REQ-002 clk  input  1  sole clock; memory writes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26].
REQ-005 funct  input  6  instruction bits [5:0].
REQ-006 rd1  input  32  register-file read port 1 (ALU operand A).
REQ-007 rd2  input  32  register-file read port 2 (ALU B when alu_src=0; store data).
REQ-008 sign_imm  input  32  sign-extended immediate (ALU B when alu_src=1).
REQ-009 mem_to_reg, mem_write, branch, jump, alu_src, reg_dst, reg_write  output  1 each  decoded controls.
REQ-010 alu_control  output  3  decoded ALU operation.
REQ-011 alu_out  output  32  ALU result; zero  output  1  high when alu_out==0; pc_src  output  1  branch AND zero.
REQ-012 read_data  output  32  data-memory read word; result  output  32  write-back value.

Function
REQ-013 Controller, ALU, read path, result mux SHALL be purely combinational; only memory storage is sequential.
REQ-014 Decode: R-type 000000 -> reg_write=1, reg_dst=1, others 0, alu_control from funct.
REQ-015 lw 100011 -> reg_write=1, alu_src=1, mem_to_reg=1, alu_control=010.
REQ-016 sw 101011 -> mem_write=1, alu_src=1, alu_control=010.
REQ-017 beq 000100 -> branch=1, alu_control=110; addi 001000 -> reg_write=1, alu_src=1, alu_control=010; j 000010 -> jump=1.
REQ-018 R-type funct: 100000->010 add, 100010->110 sub, 100100->000 and, 100101->001 or, 101010->111 slt.
REQ-019 Unknown opcode or unknown R-type funct: all 1-bit controls 0, alu_control=010.
REQ-020 ALU, B=alu_src?sign_imm:rd2: 000 A&B, 001 A|B, 010 A+B, 110 A-B, 111 signed A<B ->1 else 0, 100 A&~B, 101 A|~B, 011 -> 0; arithmetic modulo 2^32, no overflow flag.
REQ-021 Memory: 2^DEPTH_LOG2 x 32; word index = alu_out[DEPTH_LOG2+1:2]; alu_out[1:0] and upper bits ignored (address wraps).
REQ-022 read_data = mem[index] combinationally at all times, including during a store.
REQ-023 Store: on rising clk with mem_write=1 and rst=0, mem[index] <= rd2; new value visible on read_data after that edge.
REQ-024 result = mem_to_reg ? read_data : alu_out.

Reset
REQ-025 While rst=1 no memory write SHALL occur regardless of mem_write or clk.
REQ-026 Combinational outputs SHALL not depend on rst; reset asserted mid-cycle only blocks the pending write.
REQ-027 Memory-clearing behaviour on reset SHALL follow REQ-028.

Configuration
REQ-028 Macro DMEM_CLEAR_ON_RESET_EN: defined -> rst asynchronously clears every memory word to 0; undefined -> rst leaves memory contents unchanged (initial contents X).

Verification
REQ-029 opcode=000000 funct=100010 rd1=5 rd2=5 -> alu_control=110, alu_out=0, zero=1, reg_write=1, reg_dst=1.
REQ-030 opcode=000000 funct=101010 rd1=FFFFFFFF rd2=1 -> alu_out=1 (signed compare); rd1=1 rd2=FFFFFFFF -> 0.
REQ-031 sw: rd1=0x10 sign_imm=4 rd2=0xDEADBEEF, one clk edge; then lw same address -> read_data=result=0xDEADBEEF, mem_to_reg=1.
REQ-032 beq rd1=rd2=7 -> branch=1, pc_src=1; rd2=8 -> pc_src=0.
REQ-033 sw with rst=1 across a clk edge -> location unchanged (with DMEM_CLEAR_ON_RESET_EN: reads 0 after reset).
REQ-034 opcode=111111 -> all 1-bit controls 0, alu_control=010, no memory write on clk edge.
